dacx0004_sample_sequencer: RTL and testbench

//  Upstream feeder for the DACx0004 SPI driver on the 96AnalogXperience board.
//  - Accepts 4-channel sample frames on a valid/ready stream and buffers them in a small FIFO.
//  - Releases one frame per programmable sample tick onto held parallel channel outputs (o_data_ch0..3).
//  - Drives the driver's ce enable and flags underruns.

---
 rtl/dacx0004_seq_pkg.sv | 30 +++
 rtl/dacx0004_frame_fifo.sv | 78 +++++++
 rtl/dacx0004_sample_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dacx0004_sample_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dacx0004_seq_pkg.sv
// -----------------------------------------------------------------------------
// dacx0004_seq_pkg
// Shared types and constants for the DACx0004 sample sequencer.
//   seq_state_t  : sequencer FSM state (IDLE / PRIME / RUN)
//   CH_W, N_CH   : channel field width and channel count within a frame
//   FRAME_W      : packed frame width {ch3,ch2,ch1,ch0}
//   MIDSCALE     : DAC code for 0 V offset-binary midscale
//   to_dac_code  : two's complement -> offset binary conversion
// -----------------------------------------------------------------------------
package dacx0004_seq_pkg;

    localparam int CH_W    = 16;
    localparam int N_CH    = 4;
    localparam int FRAME_W = CH_W * N_CH;

    localparam logic [CH_W-1:0] MIDSCALE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [CH_W-1:0] to_dac_code(input logic [CH_W-1:0] s,
                                                    input logic signed_fmt);
        return signed_fmt ? {~s[CH_W-1], s[CH_W-2:0]} : s;
    endfunction

endpackage

// File: rtl/dacx0004_frame_fifo.sv
// -----------------------------------------------------------------------------
// dacx0004_frame_fifo
// Synchronous frame FIFO, DW bits x 2**AW entries, first-word-fall-through.
//   clk100mhz  in   system clock
//   rst        in   asynchronous reset, active-high (pointers/level only)
//   i_push     in   write request; ignored when full (even if popping)
//   i_wdata    in   write data
//   i_pop      in   read request; ignored when empty
//   o_rdata    out  head-of-queue data (valid while !o_empty)
//   o_full     out  level == 2**AW
//   o_empty    out  level == 0
//   o_level    out  entries currently stored, 0..2**AW
// -----------------------------------------------------------------------------
module dacx0004_frame_fifo #(
    parameter int AW = 4,
    parameter int DW = 64
) (
    input  logic          clk100mhz,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          push_ok;
    logic          pop_ok;

    assign o_full  = (level_reg == DEPTH);
    assign o_empty = (level_reg == '0);
    assign o_level = level_reg;

    // Full is checked against the current level only, so a pop in the same
    // cycle never frees a slot for a concurrent push.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // The head must be available in the pop cycle itself, so the read is
    // asynchronous; at 16 entries this maps to distributed RAM.
    assign o_rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk100mhz) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= i_wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo depth for free.
    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/dacx0004_sample_sequencer.sv
// -----------------------------------------------------------------------------
// dacx0004_sample_sequencer
// Buffers 4-channel sample frames and releases one per sample tick to the
// DACx0004 SPI driver as held parallel channel codes.
//   clk100mhz        in   system clock, 100 MHz
//   rst              in   asynchronous reset, active-high
//   i_enable         in   playback enable (level)
//   i_rate_div       in   tick period minus 1, clamped to >= MIN_DIV
//   i_signed_fmt     in   1: frames are two's complement, convert to offset binary
//   i_s_tdata        in   frame {ch3,ch2,ch1,ch0}
//   i_s_tvalid       in   frame valid
//   o_s_tready       out  FIFO not full
//   o_data_ch0..3    out  held DAC codes
//   o_ce             out  driver enable, high while not IDLE
//   o_tick           out  1-cycle pulse coincident with a data update
//   o_underrun       out  sticky: a tick found the FIFO empty
//   i_clr_underrun   in   clears o_underrun (a new underrun wins)
//   o_fifo_level     out  frames buffered
// -----------------------------------------------------------------------------
module dacx0004_sample_sequencer
    import dacx0004_seq_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int DIV_W       = 16,
    parameter int MIN_DIV     = 1023,
    parameter int PRIME_LEVEL = 2
) (
    input  logic               clk100mhz,
    input  logic               rst,
    input  logic               i_enable,
    input  logic [DIV_W-1:0]   i_rate_div,
    input  logic               i_signed_fmt,
    input  logic [63:0]        i_s_tdata,
    input  logic               i_s_tvalid,
    output logic               o_s_tready,
    output logic [15:0]        o_data_ch0,
    output logic [15:0]        o_data_ch1,
    output logic [15:0]        o_data_ch2,
    output logic [15:0]        o_data_ch3,
    output logic               o_ce,
    output logic               o_tick,
    output logic               o_underrun,
    input  logic               i_clr_underrun,
    output logic [FIFO_AW:0]   o_fifo_level
);

    localparam logic [DIV_W-1:0] MIN_DIV_L   = DIV_W'(MIN_DIV);
    localparam logic [FIFO_AW:0] PRIME_LVL_L = (FIFO_AW + 1)'(PRIME_LEVEL);

    seq_state_t          state_reg;
    seq_state_t          state_next;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [DIV_W-1:0]    div_eff_reg;
    logic [DIV_W-1:0]    rate_clamped;
    logic                tick_hit;
    logic                pop;
    logic                underrun_set;
    logic                ce_reg;
    logic                tick_reg;
    logic                underrun_reg;

    logic [FRAME_W-1:0]  fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_level;

    logic [CH_W-1:0]     conv_ch  [N_CH];
    logic [CH_W-1:0]     data_reg [N_CH];

    dacx0004_frame_fifo #(
        .AW (FIFO_AW),
        .DW (FRAME_W)
    ) u_fifo (
        .clk100mhz (clk100mhz),
        .rst       (rst),
        .i_push    (i_s_tvalid),
        .i_wdata   (i_s_tdata),
        .i_pop     (pop),
        .o_rdata   (fifo_rdata),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (fifo_level)
    );

    assign o_s_tready   = !fifo_full;
    assign o_fifo_level = fifo_level;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_enable) state_next = PRIME;
            PRIME:   if (!i_enable) state_next = IDLE;
                     else if (fifo_level >= PRIME_LVL_L) state_next = RUN;
            RUN:     if (!i_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ce_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Follows the state register so o_ce == (state != IDLE) every cycle.
            ce_reg    <= (state_next != IDLE);
        end
    end

    assign o_ce = ce_reg;

    // ------------------------------------------------------------ divider
    assign rate_clamped = (i_rate_div < MIN_DIV_L) ? MIN_DIV_L : i_rate_div;
    assign tick_hit     = (state_reg == RUN) && i_enable && (div_cnt_reg == div_eff_reg);
    assign pop          = tick_hit && !fifo_empty;
    assign underrun_set = tick_hit && fifo_empty;

    // The effective period is latched only outside RUN and at each wrap, so a
    // rate change never truncates or stretches the period in progress.
    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            div_eff_reg <= MIN_DIV_L;
        end else if (state_reg != RUN) begin
            div_cnt_reg <= '0;
            div_eff_reg <= rate_clamped;
        end else if (!i_enable) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == div_eff_reg) begin
            div_cnt_reg <= '0;
            div_eff_reg <= rate_clamped;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------- output stage
    // Conversion format is sampled in the pop cycle along with the frame.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign conv_ch[gi] = to_dac_code(fifo_rdata[gi*CH_W +: CH_W], i_signed_fmt);

        always_ff @(posedge clk100mhz or posedge rst) begin
            if (rst) begin
                data_reg[gi] <= MIDSCALE;
            end else if (pop) begin
                data_reg[gi] <= conv_ch[gi];
            end
        end
    end

    assign o_data_ch0 = data_reg[0];
    assign o_data_ch1 = data_reg[1];
    assign o_data_ch2 = data_reg[2];
    assign o_data_ch3 = data_reg[3];

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            tick_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            tick_reg <= pop;
            // A fresh underrun takes priority over a clear in the same cycle.
            if (underrun_set) begin
                underrun_reg <= 1'b1;
            end else if (i_clr_underrun) begin
                underrun_reg <= 1'b0;
            end
        end
    end

    assign o_tick     = tick_reg;
    assign o_underrun = underrun_reg;

endmodule

// File: tb/tb_dacx0004_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dacx0004_sample_sequencer
// Directed, self-checking bench for dacx0004_sample_sequencer.
// -----------------------------------------------------------------------------
module tb_dacx0004_sample_sequencer;

    logic        clk100mhz = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_rate_div = 16'd1023;
    logic        i_signed_fmt = 1'b0;
    logic [63:0] i_s_tdata = '0;
    logic        i_s_tvalid = 1'b0;
    logic        o_s_tready;
    logic [15:0] o_data_ch0, o_data_ch1, o_data_ch2, o_data_ch3;
    logic        o_ce, o_tick, o_underrun;
    logic        i_clr_underrun = 1'b0;
    logic [4:0]  o_fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dacx0004_sample_sequencer dut (
        .clk100mhz      (clk100mhz),
        .rst            (rst),
        .i_enable       (i_enable),
        .i_rate_div     (i_rate_div),
        .i_signed_fmt   (i_signed_fmt),
        .i_s_tdata      (i_s_tdata),
        .i_s_tvalid     (i_s_tvalid),
        .o_s_tready     (o_s_tready),
        .o_data_ch0     (o_data_ch0),
        .o_data_ch1     (o_data_ch1),
        .o_data_ch2     (o_data_ch2),
        .o_data_ch3     (o_data_ch3),
        .o_ce           (o_ce),
        .o_tick         (o_tick),
        .o_underrun     (o_underrun),
        .i_clr_underrun (i_clr_underrun),
        .o_fifo_level   (o_fifo_level)
    );

    always #5 clk100mhz = ~clk100mhz;
    always @(posedge clk100mhz) cyc <= cyc + 1;

    typedef struct packed {
        logic        fmt;
        logic [63:0] frame;
        logic [63:0] exp;   // {ch3,ch2,ch1,ch0}
    } conv_vec_t;

    conv_vec_t conv_tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk100mhz);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {o_data_ch3, o_data_ch2, o_data_ch1, o_data_ch0};
    endfunction

    function automatic logic [63:0] stream_frame(input int i);
        return {16'hA300 + 16'(i), 16'hA200 + 16'(i), 16'hA100 + 16'(i), 16'hA000 + 16'(i)};
    endfunction

    task automatic push_frame(input logic [63:0] d);
        int w;
        w = 0;
        i_s_tdata  = d;
        i_s_tvalid = 1'b1;
        while (!o_s_tready && w < 3000) begin
            step();
            w++;
        end
        if (!o_s_tready) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: tready=%0b after %0d cycles, required 1", o_s_tready, w);
        end
        step();
        i_s_tvalid = 1'b0;
    endtask

    task automatic wait_tick(output int tick_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_tick && n < 1200);
        tick_cyc = cyc;
        if (!o_tick) begin
            errors++;
            checks++;
            $display("FAIL tick_timeout: no o_tick within %0d cycles, required a tick", n);
        end
    endtask

    initial begin
        int t0, t1, tu, c0;

        conv_tbl[0] = '{1'b1, 64'hFFFF_0000_7FFF_8000, 64'h7FFF_8000_FFFF_0000};
        conv_tbl[1] = '{1'b0, 64'h1234_ABCD_0001_FFFE, 64'h1234_ABCD_0001_FFFE};
        conv_tbl[2] = '{1'b1, 64'h0001_FFFE_8001_7FFE, 64'h8001_7FFE_0001_FFFE};
        conv_tbl[3] = '{1'b0, 64'h8000_8000_0000_FFFF, 64'h8000_8000_0000_FFFF};

        // ---------------- reset state
        step();
        chk("rst_data", outs(), {4{16'h8000}});
        chk("rst_ce", 64'(o_ce), 64'd0);
        chk("rst_tick", 64'(o_tick), 64'd0);
        chk("rst_underrun", 64'(o_underrun), 64'd0);
        chk("rst_level", 64'(o_fifo_level), 64'd0);
        chk("rst_tready", 64'(o_s_tready), 64'd1);
        rst = 1'b0;
        step();

        // ---------------- prime / playback
        i_enable = 1'b1;
        step();
        chk("ce_after_enable", 64'(o_ce), 64'd1);
        push_frame(64'h1111_2222_3333_4444);
        push_frame(64'h5555_6666_7777_8888);
        c0 = cyc;
        chk("prime_level", 64'(o_fifo_level), 64'd2);
        wait_tick(t0);
        chk("first_tick_latency", 64'(t0 - c0), 64'd1025);
        chk("data_A", outs(), 64'h1111_2222_3333_4444);
        chk("level_after_A", 64'(o_fifo_level), 64'd1);
        step();
        chk("tick_one_cycle", 64'(o_tick), 64'd0);
        wait_tick(t1);
        chk("period_A_B", 64'(t1 - t0), 64'd1024);
        chk("data_B", outs(), 64'h5555_6666_7777_8888);

        // ---------------- divider clamp
        i_rate_div = 16'd10;
        push_frame(64'hC0C0_C1C1_C2C2_C3C3);
        wait_tick(t0);
        chk("period_B_C", 64'(t0 - t1), 64'd1024);
        chk("data_C", outs(), 64'hC0C0_C1C1_C2C2_C3C3);
        push_frame(64'hD0D0_D1D1_D2D2_D3D3);
        wait_tick(t1);
        chk("period_clamped", 64'(t1 - t0), 64'd1024);
        chk("data_D", outs(), 64'hD0D0_D1D1_D2D2_D3D3);

        // ---------------- conversion table
        for (int v = 0; v < 4; v++) begin
            i_signed_fmt = conv_tbl[v].fmt;
            push_frame(conv_tbl[v].frame);
            wait_tick(t0);
            chk($sformatf("conv%0d_ch0", v), 64'(o_data_ch0), 64'(conv_tbl[v].exp[15:0]));
            chk($sformatf("conv%0d_ch1", v), 64'(o_data_ch1), 64'(conv_tbl[v].exp[31:16]));
            chk($sformatf("conv%0d_ch2", v), 64'(o_data_ch2), 64'(conv_tbl[v].exp[47:32]));
            chk($sformatf("conv%0d_ch3", v), 64'(o_data_ch3), 64'(conv_tbl[v].exp[63:48]));
        end
        chk("no_underrun_yet", 64'(o_underrun), 64'd0);

        // ---------------- underrun and simultaneous events
        begin
            int w;
            w = 0;
            while (!o_underrun && w < 1200) begin
                step();
                w++;
            end
        end
        tu = cyc;
        chk("underrun_set", 64'(o_underrun), 64'd1);
        chk("underrun_period", 64'(tu - t0), 64'd1024);
        chk("underrun_no_tick", 64'(o_tick), 64'd0);
        chk("underrun_data_held", outs(), conv_tbl[3].exp);
        i_clr_underrun = 1'b1;
        step();
        i_clr_underrun = 1'b0;
        chk("clr_underrun", 64'(o_underrun), 64'd0);
        repeat (1022) step();
        i_clr_underrun = 1'b1;       // lands on the next empty tick
        step();
        i_clr_underrun = 1'b0;
        chk("set_beats_clr", 64'(o_underrun), 64'd1);
        i_clr_underrun = 1'b1;
        step();
        i_clr_underrun = 1'b0;
        chk("clr_again", 64'(o_underrun), 64'd0);
        repeat (1022) step();
        i_s_tdata  = 64'hE0E0_E1E1_E2E2_E3E3;   // push lands on an empty tick
        i_s_tvalid = 1'b1;
        step();
        i_s_tvalid = 1'b0;
        chk("push_on_empty_tick_underrun", 64'(o_underrun), 64'd1);
        chk("push_on_empty_tick_notick", 64'(o_tick), 64'd0);
        chk("push_on_empty_tick_level", 64'(o_fifo_level), 64'd1);
        wait_tick(t1);
        chk("late_frame_timing", 64'(t1 - tu), 64'd3072);
        chk("late_frame_data", outs(), 64'hE0E0_E1E1_E2E2_E3E3);
        i_clr_underrun = 1'b1;
        step();
        i_clr_underrun = 1'b0;

        // ---------------- full / wrap
        i_signed_fmt = 1'b0;
        i_enable = 1'b0;
        step();
        chk("ce_idle", 64'(o_ce), 64'd0);
        for (int i = 0; i < 16; i++) push_frame(stream_frame(i));
        chk("full_level", 64'(o_fifo_level), 64'd16);
        chk("full_tready", 64'(o_s_tready), 64'd0);
        chk("idle_data_held", outs(), 64'hE0E0_E1E1_E2E2_E3E3);
        i_enable = 1'b1;
        fork
            begin
                for (int i = 16; i < 40; i++) push_frame(stream_frame(i));
            end
            begin
                int tc;
                for (int i = 0; i < 40; i++) begin
                    wait_tick(tc);
                    chk($sformatf("stream%0d", i), outs(), stream_frame(i));
                    if (i == 0) begin
                        chk("no_push_at_full_pop", 64'(o_fifo_level), 64'd15);
                        chk("tready_after_pop", 64'(o_s_tready), 64'd1);
                    end
                end
            end
        join
        chk("stream_drained", 64'(o_fifo_level), 64'd0);
        chk("stream_no_underrun", 64'(o_underrun), 64'd0);

        // ---------------- asynchronous reset mid-RUN
        push_frame(64'h0101_0202_0303_0404);
        push_frame(64'h0505_0606_0707_0808);
        push_frame(64'h0909_0A0A_0B0B_0C0C);
        chk("pre_reset_level", 64'(o_fifo_level), 64'd3);
        chk("pre_reset_ce", 64'(o_ce), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data", outs(), {4{16'h8000}});
        chk("async_rst_ce", 64'(o_ce), 64'd0);
        chk("async_rst_tick", 64'(o_tick), 64'd0);
        chk("async_rst_level", 64'(o_fifo_level), 64'd0);
        chk("async_rst_tready", 64'(o_s_tready), 64'd1);
        step();
        rst = 1'b0;
        i_enable = 1'b0;
        step();
        chk("post_rst_underrun", 64'(o_underrun), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
